// File: rtl/mmio_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_sched_pkg
// Purpose  : Shared types and DFH constants for the MMIO RAM scheduler.
// Revision : 1.0  initial release
// ============================================================================
package mmio_sched_pkg;

    localparam logic [63:0] DFH0 = 64'h1000_0000_0028_100A;
    localparam logic [63:0] DFH1 = 64'hB6A1_5C3E_94D2_7F01;
    localparam logic [63:0] DFH2 = 64'h4E8C_2A17_D05B_9E63;

    typedef enum logic [1:0] {
        ST_INIT0 = 2'd0,
        ST_INIT1 = 2'd1,
        ST_INIT2 = 2'd2,
        ST_RUN   = 2'd3
    } t_sched_state;

    // Read metadata carried alongside the RAM latency so returns need no lookup.
    typedef struct packed {
        logic       is_host;
        logic [2:0] cid;
        logic [8:0] tid;
        logic [1:0] len;
        logic       hi;
    } t_rd_tag;

    function automatic logic [63:0] dfh_word(input logic [1:0] idx);
        case (idx)
            2'd0:    dfh_word = DFH0;
            2'd1:    dfh_word = DFH1;
            default: dfh_word = DFH2;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : N-way pointer-based round-robin arbiter; pointer moves past winner.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] win_o
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        gnt_o   = '0;
        win_o   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = PW'((int'(ptr_q) + i) % N);
            if (en_i && !w_found && req_i[w_idx]) begin
                w_found      = 1'b1;
                gnt_o[w_idx] = 1'b1;
                win_o        = w_idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (w_found) begin
            ptr_d = (win_o == PW'(N - 1)) ? '0 : win_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_ram_sched.sv
`default_nettype none
// ============================================================================
// Module   : mmio_ram_sched
// Purpose  : Shares one 1R1W RAM between MMIO (priority), DFH init and RR clients.
//            Define MMIO_DFH_PROTECT_EN to make words 0..2 read-only after init.
// Revision : 1.0  initial release
// ============================================================================
module mmio_ram_sched
    import mmio_sched_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int RAM_LAT     = 1,
    parameter int AW          = 15
) (
    input  logic                      pClk,
    input  logic                      pck_cp2af_softReset_n,
    input  logic                      host_wr_valid,
    input  logic                      host_rd_valid,
    input  logic [15:0]               host_addr,
    input  logic [1:0]                host_len,
    input  logic [8:0]                host_tid,
    input  logic [63:0]               host_wdata,
    output logic                      rsp_valid,
    output logic [8:0]                rsp_tid,
    output logic [63:0]               rsp_data,
    input  logic [NUM_CLIENTS-1:0]    cl_req,
    input  logic [NUM_CLIENTS-1:0]    cl_we,
    input  logic [NUM_CLIENTS*AW-1:0] cl_addr,
    input  logic [NUM_CLIENTS*8-1:0]  cl_be,
    input  logic [NUM_CLIENTS*64-1:0] cl_wdata,
    output logic [NUM_CLIENTS-1:0]    cl_gnt,
    output logic [NUM_CLIENTS-1:0]    cl_rvalid,
    output logic [63:0]               cl_rdata,
    output logic [AW-1:0]             ram_addr,
    output logic [7:0]                ram_be,
    output logic [63:0]               ram_wdata,
    output logic                      ram_we,
    input  logic [63:0]               ram_q,
    output logic                      init_done
);

    localparam int CIDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    t_sched_state            state_q, state_d;
    logic [AW-1:0]           ram_addr_q, ram_addr_d;
    logic [7:0]              ram_be_q, ram_be_d;
    logic [63:0]             ram_wdata_q, ram_wdata_d;
    logic                    ram_we_q, ram_we_d;
    t_rd_tag                 new_tag_d;
    logic                    new_vld_d;
    t_rd_tag                 tag_q [RAM_LAT+1];
    logic [RAM_LAT:0]        vld_q;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [8:0]              rsp_tid_q, rsp_tid_d;
    logic [63:0]             rsp_data_q, rsp_data_d;
    logic [NUM_CLIENTS-1:0]  cl_rvalid_q, cl_rvalid_d;
    logic [63:0]             cl_rdata_q, cl_rdata_d;

    logic                    w_run, w_host_act, w_cl_act, w_host_prot, w_cl_prot;
    logic [14:0]             w_host_word;
    logic [NUM_CLIENTS-1:0]  w_gnt;
    logic [CIDX_W-1:0]       w_win;
    logic [AW-1:0]           w_cl_addr;
    t_rd_tag                 w_out_tag;
    logic                    w_out_vld;

    // Lengths 10/11 are not MMIO accesses at all and leave the port to the clients.
    assign w_host_act  = (host_wr_valid | host_rd_valid) & ~host_len[1];
    assign w_host_word = host_addr[15:1];
    assign w_run       = (state_q == ST_RUN);
    assign w_cl_act    = |w_gnt;
    assign w_cl_addr   = cl_addr[int'(w_win)*AW +: AW];

`ifdef MMIO_DFH_PROTECT_EN
    assign w_host_prot = (w_host_word < 15'd3);
    assign w_cl_prot   = (w_cl_addr < AW'(3));
`else
    assign w_host_prot = 1'b0;
    assign w_cl_prot   = 1'b0;
`endif

    rr_arbiter #(
        .N  (NUM_CLIENTS),
        .PW (CIDX_W)
    ) u_arb (
        .clk_i  (pClk),
        .rst_ni (pck_cp2af_softReset_n),
        .en_i   (w_run & ~w_host_act & pck_cp2af_softReset_n),
        .req_i  (cl_req),
        .gnt_o  (w_gnt),
        .win_o  (w_win)
    );

    always_comb begin
        state_d     = state_q;
        ram_addr_d  = ram_addr_q;
        ram_be_d    = ram_be_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        new_vld_d   = 1'b0;
        new_tag_d   = '0;
        if (w_host_act) begin
            ram_addr_d = AW'(w_host_word);
            if (host_wr_valid) begin
                ram_we_d = ~w_host_prot;
                if (host_len[0]) begin
                    ram_be_d    = 8'hFF;
                    ram_wdata_d = host_wdata;
                end else if (host_addr[0]) begin
                    ram_be_d    = 8'hF0;
                    ram_wdata_d = {host_wdata[31:0], 32'h0};
                end else begin
                    ram_be_d    = 8'h0F;
                    ram_wdata_d = {32'h0, host_wdata[31:0]};
                end
            end else begin
                new_vld_d         = 1'b1;
                new_tag_d.is_host = 1'b1;
                new_tag_d.tid     = host_tid;
                new_tag_d.len     = host_len;
                new_tag_d.hi      = host_addr[0];
            end
        end else if (!w_run) begin
            ram_addr_d  = AW'(state_q);
            ram_be_d    = 8'hFF;
            ram_wdata_d = dfh_word(state_q);
            ram_we_d    = 1'b1;
            case (state_q)
                ST_INIT0: state_d = ST_INIT1;
                ST_INIT1: state_d = ST_INIT2;
                default:  state_d = ST_RUN;
            endcase
        end else if (w_cl_act) begin
            ram_addr_d  = w_cl_addr;
            ram_be_d    = cl_be[int'(w_win)*8 +: 8];
            ram_wdata_d = cl_wdata[int'(w_win)*64 +: 64];
            ram_we_d    = cl_we[w_win] & ~w_cl_prot;
            if (!cl_we[w_win]) begin
                new_vld_d     = 1'b1;
                new_tag_d.cid = 3'(w_win);
            end
        end
    end

    assign w_out_tag = tag_q[RAM_LAT];
    assign w_out_vld = vld_q[RAM_LAT];

    always_comb begin
        rsp_valid_d = w_out_vld & w_out_tag.is_host;
        rsp_tid_d   = rsp_tid_q;
        rsp_data_d  = rsp_data_q;
        cl_rdata_d  = cl_rdata_q;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cl_rvalid_d[i] = w_out_vld & ~w_out_tag.is_host & (w_out_tag.cid == 3'(i));
        end
        if (rsp_valid_d) begin
            rsp_tid_d = w_out_tag.tid;
            if (w_out_tag.len == 2'b01) begin
                rsp_data_d = ram_q;
            end else begin
                rsp_data_d = {32'h0, w_out_tag.hi ? ram_q[63:32] : ram_q[31:0]};
            end
        end
        if (w_out_vld && !w_out_tag.is_host) begin
            cl_rdata_d = ram_q;
        end
    end

    always_ff @(posedge pClk) begin
        if (!pck_cp2af_softReset_n) begin
            state_q <= ST_INIT0;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge pClk) begin
        if (!pck_cp2af_softReset_n) begin
            ram_addr_q  <= '0;
            ram_be_q    <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            vld_q       <= '0;
            for (int k = 0; k <= RAM_LAT; k++) begin
                tag_q[k] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= '0;
            rsp_data_q  <= '0;
            cl_rvalid_q <= '0;
            cl_rdata_q  <= '0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_be_q    <= ram_be_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            vld_q       <= {vld_q[RAM_LAT-1:0], new_vld_d};
            tag_q[0]    <= new_tag_d;
            for (int k = 1; k <= RAM_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_tid_q   <= rsp_tid_d;
            rsp_data_q  <= rsp_data_d;
            cl_rvalid_q <= cl_rvalid_d;
            cl_rdata_q  <= cl_rdata_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_be    = ram_be_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_tid   = rsp_tid_q;
    assign rsp_data  = rsp_data_q;
    assign cl_rvalid = cl_rvalid_q;
    assign cl_rdata  = cl_rdata_q;
    assign cl_gnt    = w_gnt;
    assign init_done = w_run & pck_cp2af_softReset_n;

endmodule
`default_nettype wire

// File: tb/tb_mmio_ram_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_ram_sched
// Purpose  : Directed self-checking bench for mmio_ram_sched with a 1-cycle RAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_mmio_ram_sched;

    localparam int N   = 2;
    localparam int LAT = 1;
    localparam int AW  = 15;
    localparam logic [63:0] DFH0 = 64'h1000_0000_0028_100A;
    localparam logic [63:0] DFH1 = 64'hB6A1_5C3E_94D2_7F01;
    localparam logic [63:0] DFH2 = 64'h4E8C_2A17_D05B_9E63;
`ifdef MMIO_DFH_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          host_wr_valid = 1'b0;
    logic          host_rd_valid = 1'b0;
    logic [15:0]   host_addr = '0;
    logic [1:0]    host_len = '0;
    logic [8:0]    host_tid = '0;
    logic [63:0]   host_wdata = '0;
    logic          rsp_valid;
    logic [8:0]    rsp_tid;
    logic [63:0]   rsp_data;
    logic [N-1:0]  cl_req = '0;
    logic [N-1:0]  cl_we = '0;
    logic [N*AW-1:0] cl_addr = '0;
    logic [N*8-1:0]  cl_be = '0;
    logic [N*64-1:0] cl_wdata = '0;
    logic [N-1:0]  cl_gnt;
    logic [N-1:0]  cl_rvalid;
    logic [63:0]   cl_rdata;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_be;
    logic [63:0]   ram_wdata;
    logic          ram_we;
    logic [63:0]   ram_q;
    logic          init_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_ram_sched #(
        .NUM_CLIENTS (N),
        .RAM_LAT     (LAT),
        .AW          (AW)
    ) dut (
        .pClk                  (clk),
        .pck_cp2af_softReset_n (rst_n),
        .host_wr_valid         (host_wr_valid),
        .host_rd_valid         (host_rd_valid),
        .host_addr             (host_addr),
        .host_len              (host_len),
        .host_tid              (host_tid),
        .host_wdata            (host_wdata),
        .rsp_valid             (rsp_valid),
        .rsp_tid               (rsp_tid),
        .rsp_data              (rsp_data),
        .cl_req                (cl_req),
        .cl_we                 (cl_we),
        .cl_addr               (cl_addr),
        .cl_be                 (cl_be),
        .cl_wdata              (cl_wdata),
        .cl_gnt                (cl_gnt),
        .cl_rvalid             (cl_rvalid),
        .cl_rdata              (cl_rdata),
        .ram_addr              (ram_addr),
        .ram_be                (ram_be),
        .ram_wdata             (ram_wdata),
        .ram_we                (ram_we),
        .ram_q                 (ram_q),
        .init_done             (init_done)
    );

    // Behavioural 1R1W RAM, byte-enabled, one-cycle read latency.
    bit [63:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 8; b++) begin
                if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
        end
        ram_q <= mem[ram_addr];
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        host_wr_valid = 1'b0;
        host_rd_valid = 1'b0;
        cl_req        = '0;
        cl_we         = '0;
    endtask

    task automatic test_init_seq();
        logic [63:0] dfh [3];
        dfh[0] = DFH0;
        dfh[1] = DFH1;
        dfh[2] = DFH2;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({ram_we, ram_be, ram_addr, ram_wdata} !== {1'b1, 8'hFF, 15'(i), dfh[i]}) begin
                errors++;
                $display("FAIL init_write[%0d]: got we=%b be=%h addr=%h data=%h, expected we=1 be=ff addr=%h data=%h",
                         i, ram_we, ram_be, ram_addr, ram_wdata, i, dfh[i]);
            end
            checks++;
            if ({init_done, rsp_valid, cl_rvalid} !== {(i == 2), 1'b0, 2'b00}) begin
                errors++;
                $display("FAIL init_status[%0d]: got done=%b rsp_valid=%b cl_rvalid=%b, expected done=%b 0 00",
                         i, init_done, rsp_valid, cl_rvalid, (i == 2));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({ram_we, init_done, rsp_valid, cl_gnt, cl_rvalid, ram_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b done=%b rsp=%b gnt=%b rv=%b addr=%h, expected all zero",
                     ram_we, init_done, rsp_valid, cl_gnt, cl_rvalid, ram_addr);
        end
        rst_n = 1'b1;
        test_init_seq();
        step();
        checks++;
        if ({ram_we, init_done} !== 2'b01) begin
            errors++;
            $display("FAIL post_init_idle: got we=%b done=%b, expected we=0 done=1", ram_we, init_done);
        end
    endtask

    task automatic test_host_read();
        host_rd_valid = 1'b1;
        host_addr = 16'h0001;
        host_len = 2'b00;
        host_tid = 9'h1A2;
        step();
        clear_inputs();
        checks++;
        if ({ram_we, ram_addr} !== {1'b0, 15'd0}) begin
            errors++;
            $display("FAIL host_rd_issue: got we=%b addr=%h, expected we=0 addr=0", ram_we, ram_addr);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL host_rd_early: got rsp_valid=%b, expected 0", rsp_valid);
        end
        step();
        checks++;
        if ({rsp_valid, rsp_tid, rsp_data} !== {1'b1, 9'h1A2, 64'h0000_0000_1000_0000}) begin
            errors++;
            $display("FAIL host_rd_rsp: got v=%b tid=%h data=%h, expected v=1 tid=1a2 data=0000000010000000",
                     rsp_valid, rsp_tid, rsp_data);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL host_rd_single: got rsp_valid=%b, expected 0", rsp_valid);
        end
    endtask

    task automatic test_write_read();
        host_wr_valid = 1'b1;
        host_addr = 16'h0011;
        host_len = 2'b00;
        host_wdata = 64'h1234_5678_DEAD_BEEF;
        step();
        clear_inputs();
        checks++;
        if ({ram_we, ram_be, ram_addr, ram_wdata} !== {1'b1, 8'hF0, 15'd8, 64'hDEAD_BEEF_0000_0000}) begin
            errors++;
            $display("FAIL wr32_hi_issue: got we=%b be=%h addr=%h data=%h, expected we=1 be=f0 addr=8 data=deadbeef00000000",
                     ram_we, ram_be, ram_addr, ram_wdata);
        end
        host_rd_valid = 1'b1;
        host_addr = 16'h0010;
        host_len = 2'b01;
        host_tid = 9'h005;
        step();
        clear_inputs();
        step();
        step();
        checks++;
        if ({rsp_valid, rsp_tid, rsp_data} !== {1'b1, 9'h005, 64'hDEAD_BEEF_0000_0000}) begin
            errors++;
            $display("FAIL wr_then_rd64: got v=%b tid=%h data=%h, expected v=1 tid=005 data=deadbeef00000000",
                     rsp_valid, rsp_tid, rsp_data);
        end
    endtask

    task automatic test_back_to_back();
        host_wr_valid = 1'b1;
        host_addr = 16'h0010;
        host_len = 2'b00;
        host_wdata = 64'hFFFF_FFFF_CAFE_F00D;
        step();
        clear_inputs();
        checks++;
        if ({ram_we, ram_be, ram_wdata} !== {1'b1, 8'h0F, 64'h0000_0000_CAFE_F00D}) begin
            errors++;
            $display("FAIL wr32_lo_issue: got we=%b be=%h data=%h, expected we=1 be=0f data=00000000cafef00d",
                     ram_we, ram_be, ram_wdata);
        end
        host_rd_valid = 1'b1;
        host_addr = 16'h0011;
        host_tid = 9'h0A1;
        step();
        host_addr = 16'h0010;
        host_tid = 9'h0A2;
        step();
        clear_inputs();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early: got rsp_valid=%b, expected 0", rsp_valid);
        end
        step();
        checks++;
        if ({rsp_valid, rsp_tid, rsp_data} !== {1'b1, 9'h0A1, 64'h0000_0000_DEAD_BEEF}) begin
            errors++;
            $display("FAIL b2b_rsp1: got v=%b tid=%h data=%h, expected v=1 tid=0a1 data=00000000deadbeef",
                     rsp_valid, rsp_tid, rsp_data);
        end
        step();
        checks++;
        if ({rsp_valid, rsp_tid, rsp_data} !== {1'b1, 9'h0A2, 64'h0000_0000_CAFE_F00D}) begin
            errors++;
            $display("FAIL b2b_rsp2: got v=%b tid=%h data=%h, expected v=1 tid=0a2 data=00000000cafef00d",
                     rsp_valid, rsp_tid, rsp_data);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_tail: got rsp_valid=%b, expected 0", rsp_valid);
        end
    endtask

    task automatic test_bad_len();
        host_rd_valid = 1'b1;
        host_addr = 16'h0000;
        host_len = 2'b10;
        host_tid = 9'h033;
        step();
        clear_inputs();
        host_wr_valid = 1'b1;
        host_addr = 16'h0040;
        host_len = 2'b11;
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL badlen_rd_issue: got we=%b, expected 0", ram_we);
        end
        step();
        clear_inputs();
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL badlen_wr_issue: got we=%b, expected 0", ram_we);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL badlen_no_rsp[%0d]: got rsp_valid=%b, expected 0", i, rsp_valid);
            end
        end
    endtask

    task automatic test_arbitration();
        logic [1:0] hist_g [15];
        bit         hist_h [15];
        logic [1:0] exp_g;
        logic [63:0] exp_d;
        bit          host;
        bit          nxt;
        nxt = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (c >= 3) begin
                checks++;
                if (cl_rvalid !== hist_g[c-3]) begin
                    errors++;
                    $display("FAIL arb_rvalid[%0d]: got %b, expected %b", c, cl_rvalid, hist_g[c-3]);
                end
                if (hist_g[c-3] != 2'b00) begin
                    exp_d = hist_g[c-3][0] ? DFH0 : 64'hDEAD_BEEF_CAFE_F00D;
                    checks++;
                    if (cl_rdata !== exp_d) begin
                        errors++;
                        $display("FAIL arb_rdata[%0d]: got %h, expected %h", c, cl_rdata, exp_d);
                    end
                end
                checks++;
                if (rsp_valid !== hist_h[c-3]) begin
                    errors++;
                    $display("FAIL arb_host_rsp[%0d]: got %b, expected %b", c, rsp_valid, hist_h[c-3]);
                end
            end
            host = (c < 12) && (c % 3 == 0);
            host_rd_valid = host;
            host_addr = 16'h0001;
            host_len = 2'b00;
            host_tid = 9'(c);
            cl_req = (c < 12) ? 2'b11 : 2'b00;
            cl_we = 2'b00;
            cl_addr = {15'd8, 15'd0};
            #1;
            if (c >= 12 || host) begin
                exp_g = 2'b00;
            end else begin
                exp_g = nxt ? 2'b10 : 2'b01;
                nxt = ~nxt;
            end
            checks++;
            if (cl_gnt !== exp_g) begin
                errors++;
                $display("FAIL arb_gnt[%0d]: got %b, expected %b", c, cl_gnt, exp_g);
            end
            hist_g[c] = exp_g;
            hist_h[c] = host;
            step();
        end
        clear_inputs();
    endtask

    task automatic test_dfh_protect();
        host_wr_valid = 1'b1;
        host_addr = 16'h0002;
        host_len = 2'b01;
        host_wdata = 64'h0123_4567_89AB_CDEF;
        step();
        clear_inputs();
        checks++;
        if ({ram_we, ram_addr} !== {~PROT, 15'd1}) begin
            errors++;
            $display("FAIL prot_host_we: got we=%b addr=%h, expected we=%b addr=1", ram_we, ram_addr, ~PROT);
        end
        host_rd_valid = 1'b1;
        host_addr = 16'h0002;
        host_len = 2'b01;
        host_tid = 9'h1FF;
        step();
        clear_inputs();
        step();
        step();
        checks++;
        if ({rsp_valid, rsp_data} !== {1'b1, PROT ? DFH1 : 64'h0123_4567_89AB_CDEF}) begin
            errors++;
            $display("FAIL prot_host_rd: got v=%b data=%h, expected v=1 data=%h",
                     rsp_valid, rsp_data, PROT ? DFH1 : 64'h0123_4567_89AB_CDEF);
        end
        cl_req = 2'b01;
        cl_we = 2'b01;
        cl_addr = {15'd0, 15'd2};
        cl_be = {8'h00, 8'hFF};
        #1;
        checks++;
        if (cl_gnt !== 2'b01) begin
            errors++;
            $display("FAIL prot_cl_gnt: got %b, expected 01", cl_gnt);
        end
        step();
        clear_inputs();
        checks++;
        if (ram_we !== ~PROT) begin
            errors++;
            $display("FAIL prot_cl_we: got we=%b, expected %b", ram_we, ~PROT);
        end
    endtask

    task automatic test_client_rw();
        cl_req = 2'b10;
        cl_we = 2'b10;
        cl_addr = {15'd30, 15'd0};
        cl_be = {8'h0F, 8'h00};
        cl_wdata = {64'hFFFF_FFFF_1357_9BDF, 64'h0};
        #1;
        checks++;
        if (cl_gnt !== 2'b10) begin
            errors++;
            $display("FAIL cl_wr_gnt: got %b, expected 10", cl_gnt);
        end
        step();
        clear_inputs();
        checks++;
        if ({ram_we, ram_be, ram_addr, ram_wdata} !== {1'b1, 8'h0F, 15'd30, 64'hFFFF_FFFF_1357_9BDF}) begin
            errors++;
            $display("FAIL cl_wr_issue: got we=%b be=%h addr=%h data=%h, expected we=1 be=0f addr=1e data=ffffffff13579bdf",
                     ram_we, ram_be, ram_addr, ram_wdata);
        end
        cl_req = 2'b01;
        cl_addr = {15'd0, 15'd30};
        step();
        clear_inputs();
        step();
        step();
        checks++;
        if ({cl_rvalid, cl_rdata} !== {2'b01, 64'h0000_0000_1357_9BDF}) begin
            errors++;
            $display("FAIL cl_rd_rsp: got rv=%b data=%h, expected rv=01 data=0000000013579bdf", cl_rvalid, cl_rdata);
        end
        step();
        checks++;
        if (cl_rvalid !== 2'b00) begin
            errors++;
            $display("FAIL cl_rd_single: got rv=%b, expected 00", cl_rvalid);
        end
    endtask

    task automatic test_reset_midop();
        host_rd_valid = 1'b1;
        host_addr = 16'h0000;
        host_len = 2'b01;
        host_tid = 9'h077;
        step();
        clear_inputs();
        cl_req = 2'b10;
        cl_addr = {15'd8, 15'd0};
        #1;
        checks++;
        if (cl_gnt !== 2'b10) begin
            errors++;
            $display("FAIL midop_gnt: got %b, expected 10", cl_gnt);
        end
        step();
        clear_inputs();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({rsp_valid, cl_rvalid, init_done, ram_we} !== 5'b0) begin
                errors++;
                $display("FAIL midop_quiet[%0d]: got rsp=%b rv=%b done=%b we=%b, expected all zero",
                         i, rsp_valid, cl_rvalid, init_done, ram_we);
            end
        end
        rst_n = 1'b1;
        test_init_seq();
        step();
    endtask

    initial begin
        test_reset();
        test_host_read();
        test_write_read();
        test_back_to_back();
        test_bad_len();
        test_arbitration();
        test_client_rw();
        test_reset_midop();
        test_host_read();
        test_dfh_protect();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
